// File: rtl/hex_display_pkg.sv
// Shared constants and helpers for the paged hex display: segment table,
// nibble decode and page index width.
package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment patterns; entry n sits at bits [n*7 +: 7] (0 at the LSB end).
  localparam logic [16*7-1:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[7*int'(nibble) +: 7];
  endfunction

  function automatic int page_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/page_btn_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on the released->pressed transition.
module page_btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk_27,
  input  logic reset,
  input  logic btn_n,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q, sync_d;
  logic          pressed_q, pressed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          sample_pressed;

  always_comb begin
    sync_d         = {sync_q[0], btn_n};
    sample_pressed = ~sync_q[1];
    pressed_d      = pressed_q;
    cnt_d          = '0;
    pulse_d        = 1'b0;
    // Any sample that agrees with the accepted state restarts the stability window.
    if (sample_pressed != pressed_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        pressed_d = sample_pressed;
        pulse_d   = sample_pressed;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_27) begin
    if (reset) begin
      sync_q    <= 2'b11;
      pressed_q <= 1'b0;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/hex_display_pager.sv
// Multi-page hex readout with button/timed page selection and freeze.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module hex_display_pager
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int NUM_CHANNELS    = 4,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int ROTATE_CYCLES   = 27000000
) (
  input  logic                                 clk_27,
  input  logic                                 reset,
  input  logic [NUM_CHANNELS*NUM_DIGITS*4-1:0] ch_data,
  input  logic                                 page_btn_n,
  input  logic                                 auto_en,
  input  logic                                 freeze,
  output logic [NUM_DIGITS*7-1:0]              hex_out,
  output logic [page_width(NUM_CHANNELS)-1:0]  page_idx,
  output logic                                 frozen
);

  localparam int W  = NUM_DIGITS * 4;
  localparam int PW = page_width(NUM_CHANNELS);
  localparam int RW = $clog2(ROTATE_CYCLES);

  logic [PW-1:0]           page_q, page_d;
  logic                    page_chg_q, page_chg_d;
  logic [RW-1:0]           rot_q, rot_d;
  logic                    frozen_q, frozen_d;
  logic [W-1:0]            disp_q, disp_d;
  logic [NUM_DIGITS*7-1:0] hex_q, hex_d;

  logic                    press;
  logic                    timeout;
  logic                    advance;
  logic [W-1:0]            sel_word;
  logic [3:0]              nib;
  logic [W-1:0]            ch_word [NUM_CHANNELS];
`ifdef LEADING_ZERO_BLANK_EN
  logic                    lead_zero;
`endif

  page_btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_page_btn (
    .clk_27     (clk_27),
    .reset      (reset),
    .btn_n      (page_btn_n),
    .press_pulse(press)
  );

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    assign ch_word[gi] = ch_data[gi*W +: W];
  end

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (page_q == PW'(k)) sel_word = ch_word[k];
    end
  end

  always_comb begin
    timeout    = auto_en && (rot_q == RW'(ROTATE_CYCLES - 1));
    advance    = (press || timeout) && (NUM_CHANNELS > 1);
    page_d     = page_q;
    if (advance) begin
      page_d = (page_q == PW'(NUM_CHANNELS - 1)) ? '0 : page_q + 1'b1;
    end
    page_chg_d = advance;
    rot_d      = (!auto_en || press || timeout) ? '0 : rot_q + 1'b1;
    frozen_d   = freeze;
    // The post-advance reload keeps a frozen display consistent with page_idx.
    disp_d     = (!frozen_q || page_chg_q) ? sel_word : disp_q;
  end

  always_comb begin
    hex_d = '1;
    nib   = 4'h0;
`ifdef LEADING_ZERO_BLANK_EN
    lead_zero = 1'b1;
`endif
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      nib = disp_q[d*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      lead_zero = lead_zero && (nib == 4'h0);
      hex_d[d*7 +: 7] = (lead_zero && d != 0) ? SEG_BLANK : hex_to_seg(nib);
`else
      hex_d[d*7 +: 7] = hex_to_seg(nib);
`endif
    end
  end

  always_ff @(posedge clk_27) begin
    if (reset) begin
      page_q     <= '0;
      page_chg_q <= 1'b0;
      rot_q      <= '0;
      frozen_q   <= 1'b0;
      disp_q     <= '0;
      hex_q      <= '1;
    end else begin
      page_q     <= page_d;
      page_chg_q <= page_chg_d;
      rot_q      <= rot_d;
      frozen_q   <= frozen_d;
      disp_q     <= disp_d;
      hex_q      <= hex_d;
    end
  end

  assign hex_out  = hex_q;
  assign page_idx = page_q;
  assign frozen   = frozen_q;

endmodule
